softmax_row_scheduler: RTL
==========================

# softmax_row_scheduler

Sequencing controller that streams a block of 32-element rows out of a single-port row BRAM and hands each complete row to the softmax datapath. Owns the BRAM address bus, absorbs BRAM read latency, assembles each row into a parallel register bank, and presents it with a valid/ready handshake. Sits between the row BRAM and the softmax engine, replacing one-shot single-row read FSMs for multi-row jobs.

## Interface
- ELEMS, 32: elements per row; power of two.
- DATA_W, 16: signed element width.
- ADDR_W, 10: BRAM word-address width.
- ROW_W, 5: width of the row-count input.
- READ_LAT, 1: BRAM read latency in cycles, 1..3.

- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  job start pulse; sampled only in IDLE.
- i_base_addr  in  ADDR_W  word address of row 0's element 0; latched on accepted start.
- i_num_rows  in  ROW_W  rows in the job; latched on accepted start.
- o_bram_en  out  1  BRAM read enable.
- o_bram_addr  out  ADDR_W  BRAM read address.
- i_bram_data  in  DATA_W  BRAM read data, valid READ_LAT cycles after address.
- o_row  out  ELEMS x DATA_W signed  assembled row, element k = address offset k.
- o_row_idx  out  ROW_W  index of the row on o_row.
- o_row_valid  out  1  o_row holds a complete row.
- i_row_ready  in  1  downstream accepts the row.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse at job end.

## Operation
- States: IDLE, FETCH, DRAIN, PRESENT, DONE.
- IDLE: i_start=1 latches base and count, clears row counter. Count 0 -> DONE; otherwise -> FETCH.
- FETCH: ELEMS cycles, element counter k=0..ELEMS-1. o_bram_en=1, o_bram_addr = base + row*ELEMS + k, modulo 2^ADDR_W (wraps silently). After k=ELEMS-1 -> DRAIN.
- DRAIN: READ_LAT cycles, o_bram_en=0. Then -> PRESENT.
- Capture: a READ_LAT-deep shift register of (enable, k) writes i_bram_data into o_row[k] when the delayed enable is set.
- PRESENT: o_row_valid=1. o_row and o_row_idx stay stable until transfer (valid & ready). On transfer: row+1 == count -> DONE; otherwise row increments -> FETCH in the next cycle.
- DONE: o_done=1 for one cycle -> IDLE.
- i_start is ignored whenever the block is not in IDLE. Latched inputs may change freely after start.
- o_row is not cleared between rows. It holds the last row after the job, until overwritten or reset.

## Timing
- Reset (asynchronous, immediate): state IDLE; o_bram_en, o_bram_addr, o_row (all elements), o_row_idx, o_row_valid, o_busy, o_done all 0. Capture pipeline cleared. Reset mid-job aborts with no o_done.
- Start at cycle 0 (IDLE, i_start=1): first address at cycle 1; last address at cycle ELEMS.
- o_row_valid rises at cycle ELEMS+READ_LAT+1 (34 with defaults).
- Back-to-back rows with i_row_ready held 1: one row per ELEMS+READ_LAT+1 cycles (34). The next row's first address comes in the cycle after the transfer.
- o_done comes in the cycle after the last transfer. o_busy falls in the cycle after o_done.
- Count 0: o_done at cycle 1; o_row_valid never asserts.
- o_busy is registered from state: high from cycle 1 through the DONE cycle.

## Configuration
- ROW_MAX_TRACK_EN defined: adds output o_row_max (DATA_W, signed, reset 0).
  - Loaded with element 0 when it is captured; afterwards updated to the signed maximum of itself and each captured element.
  - Valid and stable whenever o_row_valid=1; feeds softmax max-subtraction directly.
- ROW_MAX_TRACK_EN undefined: port and logic absent; all other behaviour identical.

## Test plan
- Single row: BRAM word a holds a, base=0, count=1, ready=1 -> addresses 0..31 on cycles 1..32; o_row[k]=k and o_row_valid at cycle 34; o_done at cycle 35.
- Three rows with backpressure: base=64, count=3, ready held low 5 cycles per row -> rows 0..2 hold o_row[k]=64+32r+k. Each row stays stable while stalled. Transfers occur exactly 3 times; then one o_done.
- Wrap and zero count: base=1008 (ADDR_W=10), count=1 -> addresses 1008..1023 then 0..15. Separately, count=0 -> o_done at cycle 1, no bram_en.
- Start while busy: i_start pulsed during FETCH and PRESENT with different base/count -> ignored; original job completes unchanged.
- Reset mid-job: assert i_rst at FETCH k=10 -> all outputs 0 immediately, no o_done. A new start after release runs a full row correctly.
- ROW_MAX_TRACK_EN: row data all negative, -200..-169, with one element = -5 -> o_row_max=-5. Row of all -32768 -> o_row_max=-32768.

Source files
------------

// File: rtl/softmax_row_scheduler.sv
// softmax_row_scheduler
// Streams a job of ELEMS-element rows out of a single-port row BRAM.
// Each row is assembled into a parallel register bank and handed to the
// softmax datapath over a valid/ready handshake.
// Optional feature macro: ROW_MAX_TRACK_EN adds o_row_max, the running
// signed maximum of the presented row.
module softmax_row_scheduler #(
   parameter int ELEMS    = 32,
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 10,
   parameter int ROW_W    = 5,
   parameter int READ_LAT = 1
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_start,
   input  logic [ADDR_W-1:0]              i_base_addr,
   input  logic [ROW_W-1:0]               i_num_rows,
   output logic                           o_bram_en,
   output logic [ADDR_W-1:0]              o_bram_addr,
   input  logic signed [DATA_W-1:0]       i_bram_data,
   output logic [ELEMS-1:0][DATA_W-1:0]   o_row,
   output logic [ROW_W-1:0]               o_row_idx,
   output logic                           o_row_valid,
   input  logic                           i_row_ready,
   output logic                           o_busy,
`ifdef ROW_MAX_TRACK_EN
   output logic signed [DATA_W-1:0]       o_row_max,
`endif
   output logic                           o_done
);

   localparam int K_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
   localparam int D_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_PRESENT,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_next;

   logic [ADDR_W-1:0]   r_base;
   logic [ROW_W-1:0]    r_count;
   logic [ROW_W-1:0]    r_row;
   logic [K_W-1:0]      r_k;
   logic [D_W-1:0]      r_drain;

   logic                r_cap_en [READ_LAT];
   logic [K_W-1:0]      r_cap_k  [READ_LAT];

   logic                w_last_k;
   logic                w_drain_end;
   logic                w_xfer;
   logic                w_last_row;
   logic [ADDR_W-1:0]   w_addr;
   logic                w_cap_en;
   logic [K_W-1:0]      w_cap_k;

`ifdef ROW_MAX_TRACK_EN
   // Signed maximum of two elements.
   function automatic logic signed [DATA_W-1:0] f_smax(
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b
   );
      return (a > b) ? a : b;
   endfunction
`endif

   assign w_last_k    = (r_k == K_W'(ELEMS - 1));
   assign w_drain_end = (r_drain == D_W'(READ_LAT - 1));
   assign w_xfer      = (r_state == S_PRESENT) && i_row_ready;
   assign w_last_row  = (({1'b0, r_row} + (ROW_W + 1)'(1)) == {1'b0, r_count});
   // Row offset is row*ELEMS; ELEMS is a power of two so it is a shift.
   // Address arithmetic wraps modulo 2^ADDR_W by truncation.
   assign w_addr      = r_base + ADDR_W'({r_row, {K_W{1'b0}}}) + ADDR_W'(r_k);
   assign w_cap_en    = r_cap_en[READ_LAT-1];
   assign w_cap_k     = r_cap_k[READ_LAT-1];
   assign o_row_idx   = r_row;

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode and state-derived outputs.
   always_comb begin
      w_next      = r_state;
      o_bram_en   = 1'b0;
      o_bram_addr = '0;
      o_row_valid = 1'b0;
      o_done      = 1'b0;
      o_busy      = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_next = (i_num_rows == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            o_bram_en   = 1'b1;
            o_bram_addr = w_addr;
            if (w_last_k) begin
               w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_drain_end) begin
               w_next = S_PRESENT;
            end
         end
         S_PRESENT: begin
            o_row_valid = 1'b1;
            if (w_xfer) begin
               w_next = w_last_row ? S_DONE : S_FETCH;
            end
         end
         S_DONE: begin
            o_done = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Job parameters, row counter, element counter and drain counter.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_base  <= '0;
         r_count <= '0;
         r_row   <= '0;
         r_k     <= '0;
         r_drain <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_base  <= i_base_addr;
                  r_count <= i_num_rows;
                  r_row   <= '0;
                  r_k     <= '0;
                  r_drain <= '0;
               end
            end
            S_FETCH: begin
               // Wraps back to 0 after the last element (ELEMS is 2^K_W).
               r_k     <= r_k + K_W'(1);
               r_drain <= '0;
            end
            S_DRAIN: begin
               r_drain <= w_drain_end ? '0 : r_drain + D_W'(1);
            end
            S_PRESENT: begin
               if (w_xfer && !w_last_row) begin
                  r_row <= r_row + ROW_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Capture pipeline: delays (enable, element index) by the BRAM latency.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < READ_LAT; i++) begin
            r_cap_en[i] <= 1'b0;
            r_cap_k[i]  <= '0;
         end
      end else begin
         r_cap_en[0] <= (r_state == S_FETCH);
         r_cap_k[0]  <= r_k;
         for (int i = 1; i < READ_LAT; i++) begin
            r_cap_en[i] <= r_cap_en[i-1];
            r_cap_k[i]  <= r_cap_k[i-1];
         end
      end
   end

   // Row register bank: returning BRAM word lands in its element slot.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_row <= '0;
      end else if (w_cap_en) begin
         o_row[w_cap_k] <= i_bram_data;
      end
   end

`ifdef ROW_MAX_TRACK_EN
   // Running row maximum: element 0 seeds it, later elements raise it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_row_max <= '0;
      end else if (w_cap_en) begin
         if (w_cap_k == '0) begin
            o_row_max <= i_bram_data;
         end else begin
            o_row_max <= f_smax(o_row_max, i_bram_data);
         end
      end
   end
`endif

endmodule
